// File: rtl/ctrl_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared definitions for the control pipeline. Holds the bit
//               positions of the fields inside the ID control word, the ALUOp
//               encodings, the unpacked control struct and a helper that
//               builds that struct from the low byte of the control word.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Bit positions inside the ID control word (only [7:0] carry meaning)
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_ALUOP_LO = 4;
    localparam int CTRL_ALUOP_HI = 5;
    localparam int CTRL_ALUSRC   = 6;
    localparam int CTRL_REGDST   = 7;

    // ALUOp encodings; this block carries them through without decoding
    localparam logic [1:0] ALUOP_RTYPE = 2'b00;
    localparam logic [1:0] ALUOP_ADD   = 2'b01;
    localparam logic [1:0] ALUOP_OR    = 2'b10;
    localparam logic [1:0] ALUOP_SUB   = 2'b11;

    // Field order mirrors the control-word bit order, MSB first
    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic [1:0] aluop;
        logic       memwrite;
        logic       memread;
        logic       memtoreg;
        logic       regwrite;
    } ctrl_t;

    localparam int CTRL_T_W = $bits(ctrl_t);

    function automatic ctrl_t unpack_ctrl(input logic [7:0] word);
        ctrl_t c;
        c.regdst   = word[CTRL_REGDST];
        c.alusrc   = word[CTRL_ALUSRC];
        c.aluop    = word[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
        c.memwrite = word[CTRL_MEMWRITE];
        c.memread  = word[CTRL_MEMREAD];
        c.memtoreg = word[CTRL_MEMTOREG];
        c.regwrite = word[CTRL_REGWRITE];
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe_if
// Description : Bundle of the ID-side inputs and the EX/MEM/WB-side control
//               outputs of ctrl_pipe.
//               master : the surrounding core (drives ID inputs, reads ctrl)
//               slave  : ctrl_pipe itself
// Revision    : 1.0 - initial release
// ============================================================================
interface ctrl_pipe_if #(
    parameter int CTRL_W = 32,
    parameter int REG_AW = 5
);
    // ID-side inputs
    logic [CTRL_W-1:0] ctrl_i;
    logic [REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0] id_rt_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              flush_i;
    logic              hold_i;

    // Stage control outputs
    logic              ex_regdst_o;
    logic              ex_alusrc_o;
    logic [1:0]        ex_aluop_o;
    logic [REG_AW-1:0] ex_dst_o;
    logic              mem_write_o;
    logic              mem_read_o;
    logic [REG_AW-1:0] mem_dst_o;
    logic              mem_regwrite_o;
    logic              wb_memtoreg_o;
    logic              wb_regwrite_o;
    logic [REG_AW-1:0] wb_dst_o;
    logic              hazard_stall_o;

    modport master (
        output ctrl_i, id_rs_i, id_rt_i, id_rd_i, flush_i, hold_i,
        input  ex_regdst_o, ex_alusrc_o, ex_aluop_o, ex_dst_o,
               mem_write_o, mem_read_o, mem_dst_o, mem_regwrite_o,
               wb_memtoreg_o, wb_regwrite_o, wb_dst_o, hazard_stall_o
    );

    modport slave (
        input  ctrl_i, id_rs_i, id_rt_i, id_rd_i, flush_i, hold_i,
        output ex_regdst_o, ex_alusrc_o, ex_aluop_o, ex_dst_o,
               mem_write_o, mem_read_o, mem_dst_o, mem_regwrite_o,
               wb_memtoreg_o, wb_regwrite_o, wb_dst_o, hazard_stall_o
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_stage_reg
// Description : Generic pipeline stage register.
//               clk_i/rst_i : clock, synchronous active-high clear
//               hold_i      : keep current contents (beats bubble_i)
//               bubble_i    : load all zeros instead of d_i
//               d_i / q_o   : next-stage data in / registered data out
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_stage_reg #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             hold_i,
    input  wire logic             bubble_i,
    input  wire logic [WIDTH-1:0] d_i,
    output logic      [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (!hold_i) begin
            data_d = bubble_i ? '0 : d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe
// Description : Carries the decoded ID control word through the ID/EX,
//               EX/MEM and MEM/WB registers together with the destination
//               register, detects load-use hazards and inserts bubbles for
//               hazards and branch flushes.
//               clk_i, rst_i : clock, synchronous active-high reset
//               bus (slave)  : ID inputs and EX/MEM/WB control outputs
//               Optional build macro CTRL_PIPE_PERF_EN adds stall_cnt_o and
//               flush_cnt_o event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int CTRL_W = 32,
    parameter int REG_AW = 5
) (
    input  wire logic   clk_i,
    input  wire logic   rst_i,
    ctrl_pipe_if.slave  bus
`ifdef CTRL_PIPE_PERF_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    localparam int c_IDEX_W  = CTRL_T_W + 2 * REG_AW;
    localparam int c_EXMEM_W = 4 + REG_AW;
    localparam int c_MEMWB_W = 2 + REG_AW;

    // Upper control-word bits carry no meaning for this block
    logic w_unused_ctrl_hi;
    assign w_unused_ctrl_hi = ^bus.ctrl_i[CTRL_W-1:8];

    // ------------------------------------------------------------------
    // ID/EX
    // ------------------------------------------------------------------
    ctrl_t               w_id_ctrl;
    logic [c_IDEX_W-1:0] idex_d;
    logic [c_IDEX_W-1:0] idex_q;
    ctrl_t               w_ex_ctrl;
    logic [REG_AW-1:0]   w_ex_rt;
    logic [REG_AW-1:0]   w_ex_rd;
    logic [REG_AW-1:0]   w_ex_dst;
    logic                w_hazard;
    logic                w_bubble;

    always_comb begin
        w_id_ctrl = unpack_ctrl(bus.ctrl_i[7:0]);
        idex_d    = {w_id_ctrl, bus.id_rt_i, bus.id_rd_i};
    end

    assign w_ex_ctrl = ctrl_t'(idex_q[c_IDEX_W-1 -: CTRL_T_W]);
    assign w_ex_rt   = idex_q[2*REG_AW-1 -: REG_AW];
    assign w_ex_rd   = idex_q[REG_AW-1:0];
    assign w_ex_dst  = w_ex_ctrl.regdst ? w_ex_rd : w_ex_rt;

    // rt is compared for every opcode on purpose: a spurious stall is cheap,
    // a missed one is a wrong result. Register 0 is never a real producer.
    assign w_hazard = w_ex_ctrl.memread && (w_ex_dst != '0) &&
                      ((w_ex_dst == bus.id_rs_i) || (w_ex_dst == bus.id_rt_i));

    // Flush and hazard together still produce exactly one bubble
    assign w_bubble = bus.flush_i || w_hazard;

    ctrl_stage_reg #(.WIDTH(c_IDEX_W)) u_idex (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hold_i   (bus.hold_i),
        .bubble_i (w_bubble),
        .d_i      (idex_d),
        .q_o      (idex_q)
    );

    // ------------------------------------------------------------------
    // EX/MEM : {memwrite, memread, memtoreg, regwrite, dst}
    // ------------------------------------------------------------------
    logic [c_EXMEM_W-1:0] exmem_d;
    logic [c_EXMEM_W-1:0] exmem_q;

    always_comb begin
        exmem_d = {w_ex_ctrl.memwrite, w_ex_ctrl.memread,
                   w_ex_ctrl.memtoreg, w_ex_ctrl.regwrite, w_ex_dst};
    end

    ctrl_stage_reg #(.WIDTH(c_EXMEM_W)) u_exmem (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hold_i   (bus.hold_i),
        .bubble_i (1'b0),
        .d_i      (exmem_d),
        .q_o      (exmem_q)
    );

    // ------------------------------------------------------------------
    // MEM/WB : {memtoreg, regwrite, dst}
    // ------------------------------------------------------------------
    logic [c_MEMWB_W-1:0] memwb_d;
    logic [c_MEMWB_W-1:0] memwb_q;

    always_comb begin
        memwb_d = exmem_q[REG_AW+1:0];
    end

    ctrl_stage_reg #(.WIDTH(c_MEMWB_W)) u_memwb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .hold_i   (bus.hold_i),
        .bubble_i (1'b0),
        .d_i      (memwb_d),
        .q_o      (memwb_q)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ex_regdst_o    = w_ex_ctrl.regdst;
    assign bus.ex_alusrc_o    = w_ex_ctrl.alusrc;
    assign bus.ex_aluop_o     = w_ex_ctrl.aluop;
    assign bus.ex_dst_o       = w_ex_dst;
    assign bus.mem_write_o    = exmem_q[REG_AW+3];
    assign bus.mem_read_o     = exmem_q[REG_AW+2];
    assign bus.mem_regwrite_o = exmem_q[REG_AW];
    assign bus.mem_dst_o      = exmem_q[REG_AW-1:0];
    assign bus.wb_memtoreg_o  = memwb_q[REG_AW+1];
    assign bus.wb_regwrite_o  = memwb_q[REG_AW];
    assign bus.wb_dst_o       = memwb_q[REG_AW-1:0];
    assign bus.hazard_stall_o = w_hazard;

`ifdef CTRL_PIPE_PERF_EN
    // ------------------------------------------------------------------
    // Bubble-cause counters; both count when both causes coincide
    // ------------------------------------------------------------------
    logic [31:0] stall_cnt_d;
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_d;
    logic [31:0] flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!bus.hold_i) begin
            if (w_hazard) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
            if (bus.flush_i) begin
                flush_cnt_d = flush_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
`default_nettype wire
